// File: rtl/hamming_enc_arbiter.sv
// rtl/hamming_enc_arbiter.sv - two-requester round-robin byte arbiter feeding an extended Hamming (8,4) encoder
//
// Accepts bytes from two valid/ready requesters, grants them round-robin and
// emits each byte as two extended Hamming (8,4) codewords on a valid/ready
// output stream.
//
// Parameters:
//   LOW_FIRST   1: low nibble encoded first, 0: high nibble first
// Ports:
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   req0_valid  requester 0 offers req0_data
//   req0_data   byte from requester 0
//   req0_ready  requester 0 byte accepted this cycle when valid
//   req1_valid  requester 1 offers req1_data
//   req1_data   byte from requester 1
//   req1_ready  requester 1 byte accepted this cycle when valid
//   cw_valid    cw_data holds a codeword
//   cw_data     extended Hamming (8,4) codeword {p4,d4,d3,d2,p3,d1,p2,p1}
//   cw_src      requester that supplied the byte
//   cw_last     second codeword of the byte
//   cw_ready    sink accepts the codeword
//   busy        a byte is being emitted
//   cw_count    accepted codewords, wraps at 16 bits

module hamming_enc_arbiter #(
    parameter bit LOW_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic [7:0]  req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [7:0]  req1_data,
    output logic        req1_ready,
    output logic        cw_valid,
    output logic [7:0]  cw_data,
    output logic        cw_src,
    output logic        cw_last,
    input  logic        cw_ready,
    output logic        busy,
    output logic [15:0] cw_count
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SEND_A = 2'd1;
    localparam logic [1:0] SEND_B = 2'd2;

    logic [1:0] state;
    logic [7:0] hold_data;
    logic       hold_src;
    logic       favour;      // requester that wins when both are valid
    logic       slot_open;
    logic       grant;
    logic       accept;
    logic [3:0] first_nib;
    logic [3:0] second_nib;

    function automatic logic [7:0] hamming_enc(input logic [3:0] d);
        logic p1, p2, p3, p4;
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[2] ^ d[3];
        p3 = d[1] ^ d[2] ^ d[3];
        p4 = ^{d, p1, p2, p3};
        return {p4, d[3], d[2], d[1], p3, d[0], p2, p1};
    endfunction

    // A new byte can be taken when idle, or while the last codeword of the
    // current byte is leaving; rst_n gates it so readies are low in reset.
    assign slot_open = rst_n && ((state == IDLE) || ((state == SEND_B) && cw_ready));
    assign grant     = (req0_valid && req1_valid) ? favour : req1_valid;

    assign req0_ready = slot_open && req0_valid && !grant;
    assign req1_ready = slot_open && req1_valid && grant;
    assign accept     = req0_ready || req1_ready;

    assign first_nib  = LOW_FIRST ? hold_data[3:0] : hold_data[7:4];
    assign second_nib = LOW_FIRST ? hold_data[7:4] : hold_data[3:0];

    assign busy     = (state != IDLE);
    assign cw_valid = (state == SEND_A) || (state == SEND_B);
    assign cw_last  = (state == SEND_B);
    assign cw_src   = cw_valid && hold_src;

    always_comb begin
        cw_data = 8'h00;
        if (state == SEND_A) begin
            cw_data = hamming_enc(first_nib);
        end else if (state == SEND_B) begin
            cw_data = hamming_enc(second_nib);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state <= SEND_A;
                SEND_A:  if (cw_ready) state <= SEND_B;
                SEND_B:  if (cw_ready) state <= accept ? SEND_A : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // accept is only ever high in IDLE or in SEND_B with cw_ready, so the
    // holding registers never change under a stalled codeword.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_data <= 8'h00;
            hold_src  <= 1'b0;
            favour    <= 1'b0;
        end else if (accept) begin
            hold_data <= grant ? req1_data : req0_data;
            hold_src  <= grant;
            favour    <= !grant;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cw_count <= 16'h0000;
        end else if (cw_valid && cw_ready) begin
            cw_count <= cw_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_hamming_enc_arbiter.sv
// tb/tb_hamming_enc_arbiter.sv - self-checking bench for hamming_enc_arbiter

module tb_hamming_enc_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0;
    logic [7:0]  req0_data = 8'h00;
    logic        req1_valid = 1'b0;
    logic [7:0]  req1_data = 8'h00;
    logic        cw_ready = 1'b0;

    logic        l_req0_ready, l_req1_ready, l_cw_valid, l_cw_src, l_cw_last, l_busy;
    logic [7:0]  l_cw_data;
    logic [15:0] l_cw_count;
    logic        h_req0_ready, h_req1_ready, h_cw_valid, h_cw_src, h_cw_last, h_busy;
    logic [7:0]  h_cw_data;
    logic [15:0] h_cw_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hamming_enc_arbiter #(.LOW_FIRST(1'b1)) dut_l (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(l_req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(l_req1_ready),
        .cw_valid(l_cw_valid), .cw_data(l_cw_data), .cw_src(l_cw_src), .cw_last(l_cw_last),
        .cw_ready(cw_ready), .busy(l_busy), .cw_count(l_cw_count)
    );

    hamming_enc_arbiter #(.LOW_FIRST(1'b0)) dut_h (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(h_req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(h_req1_ready),
        .cw_valid(h_cw_valid), .cw_data(h_cw_data), .cw_src(h_cw_src), .cw_last(h_cw_last),
        .cw_ready(cw_ready), .busy(h_busy), .cw_count(h_cw_count)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // Hamming code built from bit positions 1..7: parity bit at position 2^k
    // covers every position whose index has bit k set; p4 is overall parity.
    function automatic logic [7:0] enc(input logic [3:0] d);
        logic [7:1] h;
        logic par;
        h = '0;
        h[3] = d[0];
        h[5] = d[1];
        h[6] = d[2];
        h[7] = d[3];
        for (int k = 0; k < 3; k++) begin
            par = 1'b0;
            for (int pos = 1; pos <= 7; pos++)
                if (((pos >> k) & 1) == 1 && pos != (1 << k)) par = par ^ h[pos];
            h[1 << k] = par;
        end
        return {^h, h};
    endfunction

    // Model: a queue of pending codewords. A byte enters as two entries; the
    // arbiter may take a byte only when the queue will be empty after this
    // cycle's output handshake.
    typedef struct packed {
        logic [7:0] b;
        logic       s;
        logic       l;
    } ent_t;

    ent_t        q[$];
    logic        favour_m = 1'b0;
    logic [15:0] count_m = 16'h0000;

    function automatic logic m_slot();
        return (q.size() == 0) || (q.size() == 1 && cw_ready);
    endfunction

    function automatic logic m_winner();
        if (req0_valid && !req1_valid) return 1'b0;
        if (req1_valid && !req0_valid) return 1'b1;
        return favour_m;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic take, w;
        ent_t e;
        if (!rst_n) begin
            q.delete();
            favour_m = 1'b0;
            count_m  = 16'h0000;
        end else begin
            take = m_slot() && (req0_valid || req1_valid);
            w    = m_winner();
            if (q.size() > 0 && cw_ready) begin
                void'(q.pop_front());
                count_m = count_m + 16'd1;
            end
            if (take) begin
                e.b = w ? req1_data : req0_data;
                e.s = w;
                e.l = 1'b0;
                q.push_back(e);
                e.l = 1'b1;
                q.push_back(e);
                favour_m = !w;
            end
        end
    end

    always @(negedge clk) begin
        logic       ev, es, elast, er0, er1;
        logic [7:0] el, eh;
        ev = 0; es = 0; elast = 0; el = 0; eh = 0;
        if (q.size() > 0) begin
            ev    = 1'b1;
            es    = q[0].s;
            elast = q[0].l;
            el    = enc(elast ? q[0].b[7:4] : q[0].b[3:0]);
            eh    = enc(elast ? q[0].b[3:0] : q[0].b[7:4]);
        end
        er0 = rst_n && m_slot() && req0_valid && (m_winner() == 1'b0);
        er1 = rst_n && m_slot() && req1_valid && (m_winner() == 1'b1);
        chk("l_cw_valid", 16'(l_cw_valid), 16'(ev));
        chk("l_cw_data",  16'(l_cw_data),  16'(el));
        chk("l_cw_src",   16'(l_cw_src),   16'(es));
        chk("l_cw_last",  16'(l_cw_last),  16'(elast));
        chk("l_busy",     16'(l_busy),     16'(ev));
        chk("l_cw_count", l_cw_count,      count_m);
        chk("l_req0_ready", 16'(l_req0_ready), 16'(er0));
        chk("l_req1_ready", 16'(l_req1_ready), 16'(er1));
        chk("h_cw_valid", 16'(h_cw_valid), 16'(ev));
        chk("h_cw_data",  16'(h_cw_data),  16'(eh));
        chk("h_cw_src",   16'(h_cw_src),   16'(es));
        chk("h_cw_last",  16'(h_cw_last),  16'(elast));
        chk("h_busy",     16'(h_busy),     16'(ev));
        chk("h_cw_count", h_cw_count,      count_m);
        chk("h_req0_ready", 16'(h_req0_ready), 16'(er0));
        chk("h_req1_ready", 16'(h_req1_ready), 16'(er1));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        cw_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] saved;

        // Reset state, readies held low even with a request pending.
        req0_valid = 1'b1;
        tick();
        tick();
        #1;
        chk("rst_count", l_cw_count, 16'h0000);
        chk("rst_busy", 16'(l_busy), 16'h0000);
        chk("rst_ready0", 16'(l_req0_ready), 16'h0000);
        chk("rst_valid", 16'(l_cw_valid), 16'h0000);
        req0_valid = 1'b0;
        tick();
        rst_n = 1'b1;

        // Single byte 0xB1 from req0; also the high-first instance.
        req0_valid = 1'b1; req0_data = 8'hB1; cw_ready = 1'b1;
        #1 chk("b1_ready0", 16'(l_req0_ready), 16'h0001);
        tick();
        req0_valid = 1'b0; req0_data = 8'hEE;
        #1;
        chk("b1_first", 16'(l_cw_data), 16'h0087);
        chk("b1_first_last", 16'(l_cw_last), 16'h0000);
        chk("b1_hi_first", 16'(h_cw_data), 16'h0055);
        tick();
        #1;
        chk("b1_second", 16'(l_cw_data), 16'h0055);
        chk("b1_second_last", 16'(l_cw_last), 16'h0001);
        chk("b1_src", 16'(l_cw_src), 16'h0000);
        chk("b1_hi_second", 16'(h_cw_data), 16'h0087);
        tick();
        #1;
        chk("b1_idle_valid", 16'(l_cw_valid), 16'h0000);
        chk("b1_count", l_cw_count, 16'h0002);

        // Contention right after reset: req0 first, then req1.
        do_reset();
        req0_valid = 1'b1; req0_data = 8'hAF;
        req1_valid = 1'b1; req1_data = 8'h00;
        cw_ready = 1'b1;
        #1;
        chk("af_ready0", 16'(l_req0_ready), 16'h0001);
        chk("af_ready1", 16'(l_req1_ready), 16'h0000);
        tick();
        req0_valid = 1'b0;
        #1 chk("af_cw0", {7'd0, l_cw_src, l_cw_data}, 16'h00FF);
        tick();
        #1;
        chk("af_cw1", {7'd0, l_cw_src, l_cw_data}, 16'h00D2);
        chk("af_ready1_b", 16'(l_req1_ready), 16'h0001);
        tick();
        req1_valid = 1'b0;
        #1 chk("af_cw2", {6'd0, l_cw_last, l_cw_src, l_cw_data}, 16'h0100);
        tick();
        #1 chk("af_cw3", {6'd0, l_cw_last, l_cw_src, l_cw_data}, 16'h0300);
        tick();
        #1 chk("af_idle", 16'(l_cw_valid), 16'h0000);

        // Both requesters continuously valid for four bytes.
        req0_valid = 1'b1; req0_data = 8'h3C;
        req1_valid = 1'b1; req1_data = 8'hC3;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 6) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
            #1;
            chk("rr_valid", 16'(l_cw_valid), 16'h0001);
            if (i % 2 == 0) chk("rr_src", 16'(l_cw_src), 16'((i / 2) % 2));
        end
        tick();
        #1 chk("rr_done", 16'(l_cw_valid), 16'h0000);

        // Back-pressure in SEND_A with other requests pending.
        req0_valid = 1'b1; req0_data = 8'hB1; cw_ready = 1'b1;
        tick();
        req0_data = 8'h12;
        req1_valid = 1'b1; req1_data = 8'h34;
        cw_ready = 1'b0;
        saved = l_cw_count;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_data", 16'(l_cw_data), 16'h0087);
            chk("bp_ready0", 16'(l_req0_ready), 16'h0000);
            chk("bp_ready1", 16'(l_req1_ready), 16'h0000);
            chk("bp_count", l_cw_count, saved);
            tick();
        end
        cw_ready = 1'b1;
        #1 chk("bp_release_data", 16'(l_cw_data), 16'h0087);
        tick();
        #1;
        chk("bp_second", 16'(l_cw_data), 16'h0055);
        chk("bp_ready1_b", 16'(l_req1_ready), 16'h0001);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        tick();

        // Reset pulsed in SEND_B discards the byte.
        req0_valid = 1'b1; req0_data = 8'h5A; cw_ready = 1'b1;
        tick();
        req0_valid = 1'b0;
        tick();
        #1;
        chk("mr_in_send_b", 16'(l_cw_last), 16'h0001);
        rst_n = 1'b0;
        #1;
        chk("mr_valid", 16'(l_cw_valid), 16'h0000);
        chk("mr_busy", 16'(l_busy), 16'h0000);
        chk("mr_count", l_cw_count, 16'h0000);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("mr_quiet", 16'(l_cw_valid), 16'h0000);
            tick();
        end
        req1_valid = 1'b1; req1_data = 8'h96;
        tick();
        req1_valid = 1'b0;
        #1 chk("mr_new0", {7'd0, l_cw_src, l_cw_data}, 16'h0133);
        tick();
        #1 chk("mr_new1", {7'd0, l_cw_src, l_cw_data}, 16'h01CC);
        tick();
        #1 chk("mr_count_after", l_cw_count, 16'h0002);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
